// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Responder end of the core's instruction-fetch interface. It accepts a fetch
//   byte address from the PC stage and returns the 32-bit instruction word read
//   from on-chip instruction RAM after a programmable number of wait states. It
//   raises hold_out while a good fetch is outstanding. Misaligned or out-of-range
//   fetches complete in one cycle with NOP_WORD and a fault cause, and the RAM is
//   not read for them. A loader port writes program images into the RAM in any
//   state, including during reset.
//
// Ports
//   clk_in           system clock, rising edge
//   rst_in           synchronous reset, active-high
//   i_addr_in        fetch byte address, valid while i_req_in is high
//   i_req_in         fetch request
//   instr_out        fetched instruction word (held until the next response)
//   instr_valid_out  one-cycle pulse marking a response
//   hold_out         stall request to the core while a good fetch is pending
//   fault_out        delivered response is a faulted fetch
//   fault_cause_out  2'b00 none, 2'b01 misaligned, 2'b10 out of range
//   prog_we_in       loader write enable
//   prog_addr_in     loader word address
//   prog_data_in     loader write data
//
// ADDR_WIDTH must be at most 29 so that an out-of-range address field exists.

module instr_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [31:0]           i_addr_in,
  input  logic                  i_req_in,
  output logic [31:0]           instr_out,
  output logic                  instr_valid_out,
  output logic                  hold_out,
  output logic                  fault_out,
  output logic [1:0]            fault_cause_out,
  input  logic                  prog_we_in,
  input  logic [ADDR_WIDTH-1:0] prog_addr_in,
  input  logic [31:0]           prog_data_in
);

  localparam int unsigned DEPTH         = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_CNT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_RESP
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [31:0]             mem [DEPTH];

  logic accepting;
  logic misaligned;
  logic out_of_range;
  logic good_req;

  // Request classification is combinational so hold_out can be raised in the
  // same cycle a good request is presented; misalignment takes precedence.
  always_comb begin
    accepting    = (state == ST_IDLE) || (state == ST_RESP);
    misaligned   = (i_addr_in[1:0] != 2'b00);
    out_of_range = (i_addr_in[31:ADDR_WIDTH+2] != '0);
    good_req     = !misaligned && !out_of_range;
    hold_out     = (state == ST_WAIT) || (state == ST_READ) ||
                   (accepting && i_req_in && good_req);
  end

  // Loader port: unaffected by reset so images can be written while the core
  // is held in reset.
  always_ff @(posedge clk_in) begin
    if (prog_we_in) begin
      mem[prog_addr_in] <= prog_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      word_idx        <= '0;
      instr_out       <= NOP_WORD;
      instr_valid_out <= 1'b0;
      fault_out       <= 1'b0;
      fault_cause_out <= 2'b00;
    end else begin
      instr_valid_out <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (i_req_in) begin
            word_idx <= i_addr_in[ADDR_WIDTH+1:2];
            if (!good_req) begin
              // Faults respond directly without touching the RAM.
              state           <= ST_RESP;
              instr_valid_out <= 1'b1;
              instr_out       <= NOP_WORD;
              fault_out       <= 1'b1;
              fault_cause_out <= misaligned ? 2'b01 : 2'b10;
            end else begin
              wait_cnt <= WAIT_CNT_INIT;
              state    <= (WAIT_STATES == 0) ? ST_READ : ST_WAIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_READ;
          end
        end
        ST_READ: begin
          // Non-blocking read alongside the loader write gives read-before-write.
          instr_out       <= mem[word_idx];
          fault_out       <= 1'b0;
          fault_cause_out <= 2'b00;
          instr_valid_out <= 1'b1;
          state           <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder
//   Randomised bench for instr_mem_responder. The driver keeps a word-array
//   model of the instruction RAM and, whenever a request is accepted, pushes the
//   expected response (data, fault, cause, delivery cycle) into a queue. A
//   separate monitor pops and compares on every instr_valid_out pulse, and on
//   every other cycle checks held outputs and hold_out.

module tb_instr_mem_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned WS  = 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic [31:0]   i_addr_in = '0;
  logic          i_req_in = 1'b0;
  logic [31:0]   instr_out;
  logic          instr_valid_out;
  logic          hold_out;
  logic          fault_out;
  logic [1:0]    fault_cause_out;
  logic          prog_we_in = 1'b0;
  logic [AW-1:0] prog_addr_in = '0;
  logic [31:0]   prog_data_in = '0;

  instr_mem_responder #(
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS),
    .NOP_WORD   (NOP)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .i_addr_in      (i_addr_in),
    .i_req_in       (i_req_in),
    .instr_out      (instr_out),
    .instr_valid_out(instr_valid_out),
    .hold_out       (hold_out),
    .fault_out      (fault_out),
    .fault_cause_out(fault_cause_out),
    .prog_we_in     (prog_we_in),
    .prog_addr_in   (prog_addr_in),
    .prog_data_in   (prog_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  cause;
    int          due;
  } resp_t;

  resp_t         sb[$];
  logic [31:0]   mem_m [1 << AW];

  int            n_checks = 0;
  int            n_fail   = 0;
  bit            chk_en   = 0;
  logic          exp_hold = 1'b0;
  logic [31:0]   held_instr = NOP;
  logic          held_fault = 1'b0;
  logic [1:0]    held_cause = 2'b00;

  int            resp_cycle = 0;
  int            issue_c    = -10;
  bit            pend_good  = 0;
  logic [AW-1:0] pend_word  = '0;
  bit            accepted   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s at cycle %0d: bound expired", nm, cyc);
  endtask

  // Reset clears the expected held outputs from the next cycle on.
  always @(posedge clk) begin
    if (rst_in) begin
      held_instr = NOP;
      held_fault = 1'b0;
      held_cause = 2'b00;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (chk_en) begin
      resp_t e;
      if (instr_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(instr_valid_out), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          chk("instr", instr_out, e.instr);
          chk("fault", 32'(fault_out), 32'(e.fault));
          chk("cause", 32'(fault_cause_out), 32'(e.cause));
          held_instr = e.instr;
          held_fault = e.fault;
          held_cause = e.cause;
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("missing_valid", 32'(instr_valid_out), 32'd1);
        end
        chk("held_instr", instr_out, held_instr);
        chk("held_fault", 32'(fault_out), 32'(held_fault));
        chk("held_cause", 32'(fault_cause_out), 32'(held_cause));
      end
      chk("hold_out", 32'(hold_out), 32'(exp_hold));
    end
  end

  // One clock cycle of stimulus. A request is accepted by the model only when
  // the previous fetch has reached its response cycle; otherwise it is noise.
  task automatic step(input bit rs, input bit rq, input logic [31:0] a,
                      input bit we, input logic [AW-1:0] wa, input logic [31:0] wd);
    int          c;
    resp_t       e;
    bit          we_eff;
    logic [AW-1:0] w;
    @(posedge clk);
    #1;
    c         = cyc;
    accepted  = 0;
    rst_in    = rs;
    i_addr_in = a;
    if (rs) begin
      i_req_in = 1'b0;
      exp_hold = pend_good && (c > issue_c) && (c < resp_cycle);
      if (sb.size() > 0 && sb[sb.size()-1].due > c) sb.delete(sb.size()-1);
      pend_good  = 0;
      resp_cycle = c + 1;
    end else if (c >= resp_cycle) begin
      i_req_in = rq;
      exp_hold = 1'b0;
      if (rq) begin
        accepted = 1;
        w = a[AW+1:2];
        if (a[1:0] != 2'b00)
          e = '{instr: NOP, fault: 1'b1, cause: 2'b01, due: c + 1};
        else if (a[31:AW+2] != '0)
          e = '{instr: NOP, fault: 1'b1, cause: 2'b10, due: c + 1};
        else
          e = '{instr: mem_m[w], fault: 1'b0, cause: 2'b00, due: c + int'(WS) + 2};
        sb.push_back(e);
        resp_cycle = e.due;
        issue_c    = c;
        pend_good  = !e.fault;
        pend_word  = w;
        exp_hold   = !e.fault;
      end
    end else begin
      i_req_in = rq;
      exp_hold = pend_good && (c > issue_c);
    end
    // A write to the word being fetched is only allowed in its RAM read
    // cycle, where the old data must still be returned.
    we_eff = we;
    if (we && pend_good && wa == pend_word && c >= issue_c && c + 2 <= resp_cycle)
      we_eff = 0;
    prog_we_in   = we_eff;
    prog_addr_in = wa;
    prog_data_in = wd;
    if (we_eff) mem_m[wa] = wd;
  endtask

  task automatic idle();
    step(0, 0, $urandom, 0, '0, '0);
  endtask

  task automatic fetch(input logic [31:0] a);
    for (int i = 0; i < 64; i++) begin
      step(0, 1, a, 0, '0, '0);
      if (accepted) return;
    end
    bound_fail("accept_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 64) begin
      idle();
      n++;
    end
    if (sb.size() > 0) bound_fail("drain_timeout");
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] base;
    int          sel;

    // Words 0..3 are loaded while reset is held.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, '0, 1, AW'(i), 32'hA0 + 32'(i));
      chk_en = 1;
    end
    for (int i = 4; i < 16; i++) step(0, 0, '0, 1, AW'(i), $urandom);
    step(0, 0, '0, 1, AW'(1023), 32'hC0FFEE01);
    idle();

    // Single good fetch
    fetch(32'h0);
    drain();

    // Back-to-back fetches, second accepted in the RESP cycle of the first
    fetch(32'h4);
    for (int i = 0; i < 2; i++) step(0, 1, 32'h4, 0, '0, '0);
    fetch(32'h8);
    drain();

    // Misaligned and out-of-range faults, top word of the RAM
    fetch(32'h6);
    drain();
    fetch(32'h1000);
    fetch(32'hFFC);
    drain();

    // Loader write in the read cycle returns old data; refetch sees new data
    fetch(32'h8);
    idle();
    step(0, 0, '0, 1, AW'(2), 32'h0000BEEF);
    fetch(32'h8);
    drain();

    // Reset while waiting abandons the fetch; RAM survives
    fetch(32'h0);
    step(1, 0, '0, 0, '0, '0);
    idle();
    idle();
    fetch(32'h0);
    drain();

    // Randomised traffic with noise requests, loader writes and rare resets
    for (int i = 0; i < 600; i++) begin
      sel  = $urandom_range(0, 9);
      base = 32'($urandom_range(0, 15)) << 2;
      case (sel)
        6:       a = 32'hFFC;
        7:       a = base | 32'($urandom_range(1, 3));
        8:       a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        9:       a = $urandom | 32'h8000_0000;
        default: a = base;
      endcase
      step($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0, a,
           $urandom_range(0, 2) == 0,
           ($urandom_range(0, 7) == 0) ? AW'(1023) : AW'($urandom_range(0, 15)),
           $urandom);
    end
    drain();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
